// File: rtl/gyro_spi_slave.sv
// ---------------------------------------------------------------------------
// gyro_spi_slave
// SPI Mode-0 responder living in the DAC_CLK domain. An external host reads
// live loop variables and writes control words through a 40-bit frame:
// an 8-bit command (bit7 = read, bits[6:0] = address) followed by 32 data
// bits, both MSB first. The host pins are oversampled, so i_clk must run at
// least 8x faster than SCLK.
//
// Ports:
//   i_clk        system clock (DAC_CLK)
//   i_rst_n      asynchronous active-low reset (release synchronised inside)
//   i_sclk       host SPI clock, asynchronous
//   i_cs_n       host chip select, active low, asynchronous
//   i_mosi       host data in, asynchronous
//   o_miso       data to host, updated on SCLK fall
//   o_miso_oe    MISO output enable, high while a frame is open
//   i_rd_data    NUM_RD flattened 32-bit read channels, channel k at [32k+:32]
//   o_rd_strobe  one-cycle pulse when the read snapshot is taken
//   o_wr_addr    address of the last completed write (held)
//   o_wr_data    data of the last completed write (held)
//   o_wr_en      one-cycle write strobe
//   o_busy       high while the frame is in its command or data phase
//   o_frame_err  one-cycle pulse when the host aborts a frame early
// ---------------------------------------------------------------------------
module gyro_spi_slave #(
  parameter int NUM_RD      = 8,
  parameter int SYNC_STAGES = 2   // must be at least 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_sclk,
  input  logic                   i_cs_n,
  input  logic                   i_mosi,
  output logic                   o_miso,
  output logic                   o_miso_oe,
  input  logic [NUM_RD*32-1:0]   i_rd_data,
  output logic                   o_rd_strobe,
  output logic [6:0]             o_wr_addr,
  output logic [31:0]            o_wr_data,
  output logic                   o_wr_en,
  output logic                   o_busy,
  output logic                   o_frame_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Last bit index of the frame (8 command + 32 data bits, counted from 0).
  localparam logic [5:0] LAST_BIT       = 6'd39;
  localparam logic [5:0] LAST_CMD_BIT   = 6'd7;
  // Counter value once the first data bit has been sampled.
  localparam logic [5:0] FIRST_DATA_CNT = 6'd9;

  // Reset synchroniser: assertion is immediate, release follows i_clk.
  logic [1:0]             rst_sync_q;
  logic                   rst_n_s;

  // Pin synchronisers and edge history.
  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic                   sclk_prev_q;
  logic                   cs_prev_q;

  logic                   sclk_s;
  logic                   cs_s;
  logic                   mosi_s;
  logic                   sclk_rise_s;
  logic                   sclk_fall_s;
  logic                   cs_rise_s;
  logic                   cs_fall_s;

  // Frame state.
  state_e                 state_q;
  logic [5:0]             bit_cnt_q;
  logic [5:0]             bit_cnt_d;
  logic [6:0]             cmd_sh_q;
  logic                   cmd_rd_q;
  logic [6:0]             cmd_addr_q;
  logic [31:0]            rx_sh_q;
  logic [31:0]            tx_sh_q;
  logic [6:0]             cmd_addr_s;
  logic [31:0]            rd_word_s;

  // Registered outputs.
  logic                   miso_q;
  logic                   miso_oe_q;
  logic                   rd_strobe_q;
  logic [6:0]             wr_addr_q;
  logic [31:0]            wr_data_q;
  logic                   wr_en_q;
  logic                   busy_q;
  logic                   frame_err_q;

  // Stretch the external reset so its release is aligned to i_clk.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n_s = rst_sync_q[1];

  // Bring the host pins into the i_clk domain and keep one cycle of history.
  // CS resets to its inactive (high) level so that leaving reset never looks
  // like a chip-select edge.
  always_ff @(posedge i_clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      sclk_sync_q <= {SYNC_STAGES{1'b0}};
      cs_sync_q   <= {SYNC_STAGES{1'b1}};
      mosi_sync_q <= {SYNC_STAGES{1'b0}};
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], i_sclk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], i_cs_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], i_mosi};
      sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
      cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
    end
  end

  assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s        = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise_s = sclk_s & ~sclk_prev_q;
  assign sclk_fall_s = ~sclk_s & sclk_prev_q;
  assign cs_rise_s   = cs_s & ~cs_prev_q;
  assign cs_fall_s   = ~cs_s & cs_prev_q;

  // Saturating bit counter: it stops at the last frame bit and never wraps.
  assign bit_cnt_d  = (bit_cnt_q == LAST_BIT) ? bit_cnt_q : (bit_cnt_q + 6'd1);

  // Address as it will be once the 8th command bit is shifted in.
  assign cmd_addr_s = {cmd_sh_q[5:0], mosi_s};

  // Read channel mux; out-of-range addresses read as zero.
  always_comb begin
    rd_word_s = 32'h0000_0000;
    for (int k = 0; k < NUM_RD; k++) begin
      rd_word_s = (cmd_addr_s == 7'(k)) ? i_rd_data[k*32 +: 32] : rd_word_s;
    end
  end

  // Frame FSM with all outputs registered. A CS rise is examined before any
  // SCLK edge so that an abort always wins over a coincident clock edge.
  always_ff @(posedge i_clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 6'd0;
      cmd_sh_q    <= 7'd0;
      cmd_rd_q    <= 1'b0;
      cmd_addr_q  <= 7'd0;
      rx_sh_q     <= 32'h0000_0000;
      tx_sh_q     <= 32'h0000_0000;
      miso_q      <= 1'b0;
      miso_oe_q   <= 1'b0;
      rd_strobe_q <= 1'b0;
      wr_addr_q   <= 7'd0;
      wr_data_q   <= 32'h0000_0000;
      wr_en_q     <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rd_strobe_q <= 1'b0;
      wr_en_q     <= 1'b0;
      frame_err_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          miso_q <= 1'b0;
          if (cs_fall_s) begin
            state_q   <= ST_CMD;
            bit_cnt_q <= 6'd0;
            cmd_sh_q  <= 7'd0;
            rx_sh_q   <= 32'h0000_0000;
            tx_sh_q   <= 32'h0000_0000;
            miso_oe_q <= 1'b1;
            busy_q    <= 1'b1;
          end
        end

        ST_CMD: begin
          miso_q <= 1'b0;
          if (cs_rise_s) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 6'd0;
            tx_sh_q     <= 32'h0000_0000;
            miso_oe_q   <= 1'b0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b1;
          end else if (sclk_rise_s) begin
            cmd_sh_q  <= {cmd_sh_q[5:0], mosi_s};
            bit_cnt_q <= bit_cnt_d;
            if (bit_cnt_q == LAST_CMD_BIT) begin
              cmd_rd_q   <= cmd_sh_q[6];
              cmd_addr_q <= cmd_addr_s;
              state_q    <= ST_DATA;
              if (cmd_sh_q[6]) begin
                // Whole word captured in one cycle: no tearing.
                tx_sh_q     <= rd_word_s;
                rd_strobe_q <= 1'b1;
              end else begin
                tx_sh_q <= 32'h0000_0000;
              end
            end
          end
        end

        ST_DATA: begin
          if (cs_rise_s) begin
            // Early CS rise: drop the frame, including any read snapshot.
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 6'd0;
            tx_sh_q     <= 32'h0000_0000;
            rx_sh_q     <= 32'h0000_0000;
            miso_q      <= 1'b0;
            miso_oe_q   <= 1'b0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b1;
          end else if (sclk_rise_s) begin
            rx_sh_q   <= {rx_sh_q[30:0], mosi_s};
            bit_cnt_q <= bit_cnt_d;
            if (bit_cnt_q == LAST_BIT) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              miso_q  <= 1'b0;
              if (!cmd_rd_q) begin
                wr_en_q   <= 1'b1;
                wr_addr_q <= cmd_addr_q;
                wr_data_q <= {rx_sh_q[30:0], mosi_s};
              end
            end else begin
              miso_q <= tx_sh_q[31];
            end
          end else if (sclk_fall_s && (bit_cnt_q >= FIRST_DATA_CNT)) begin
            // The fall between the last command bit and the first data bit
            // must keep bit 31 on the line, hence the counter guard.
            tx_sh_q <= {tx_sh_q[30:0], 1'b0};
            miso_q  <= tx_sh_q[31];
          end else begin
            miso_q <= tx_sh_q[31];
          end
        end

        ST_DONE: begin
          // Extra SCLK edges and CS falls are ignored until CS goes high.
          miso_q <= 1'b0;
          if (cs_rise_s) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= 6'd0;
            miso_oe_q <= 1'b0;
          end
        end

        default: begin
          state_q   <= ST_IDLE;
          bit_cnt_q <= 6'd0;
          miso_q    <= 1'b0;
          miso_oe_q <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign o_miso      = miso_q;
  assign o_miso_oe   = miso_oe_q;
  assign o_rd_strobe = rd_strobe_q;
  assign o_wr_addr   = wr_addr_q;
  assign o_wr_data   = wr_data_q;
  assign o_wr_en     = wr_en_q;
  assign o_busy      = busy_q;
  assign o_frame_err = frame_err_q;

endmodule

// File: tb/tb_gyro_spi_slave.sv
// ---------------------------------------------------------------------------
// Bench for gyro_spi_slave. A host task drives SPI Mode-0 frames with
// SCLK = i_clk/16; the expected outcome of each frame (strobes, writes,
// aborts, returned read word) is derived from the frame's shape alone, and a
// per-cycle monitor checks output invariants and every write strobe.
// ---------------------------------------------------------------------------
module tb_gyro_spi_slave;

  localparam int NUM_RD = 8;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 sclk = 1'b0;
  logic                 cs_n = 1'b1;
  logic                 mosi = 1'b0;
  logic [NUM_RD*32-1:0] rd_data = '0;
  logic [NUM_RD*32-1:0] rd_seen = '0;

  logic                 o_miso, o_miso_oe, o_rd_strobe, o_wr_en, o_busy, o_frame_err;
  logic [6:0]           o_wr_addr;
  logic [31:0]          o_wr_data;
  logic [44:0]          outs;

  int                   n_cmp = 0;
  int                   n_err = 0;
  int                   host_bit = 0;
  int                   cur_addr = 0;
  int                   cs_high_cnt = 0;
  int                   obs_strobe = 0, obs_err = 0, obs_wr = 0;
  int                   exp_strobe = 0, exp_err = 0, exp_wr = 0;
  logic [31:0]          snap_exp = 32'h0;
  logic [38:0]          exp_wr_q[$];
  logic [6:0]           last_addr = 7'h0;
  logic [31:0]          last_data = 32'h0;
  logic                 inc_ch2 = 1'b0;

  always #5 clk = ~clk;

  gyro_spi_slave #(.NUM_RD(NUM_RD), .SYNC_STAGES(2)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_sclk     (sclk),
    .i_cs_n     (cs_n),
    .i_mosi     (mosi),
    .o_miso     (o_miso),
    .o_miso_oe  (o_miso_oe),
    .i_rd_data  (rd_data),
    .o_rd_strobe(o_rd_strobe),
    .o_wr_addr  (o_wr_addr),
    .o_wr_data  (o_wr_data),
    .o_wr_en    (o_wr_en),
    .o_busy     (o_busy),
    .o_frame_err(o_frame_err)
  );

  assign outs = {o_miso, o_miso_oe, o_rd_strobe, o_wr_addr, o_wr_data, o_wr_en, o_busy, o_frame_err};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // What the DUT saw on i_rd_data at each active edge.
  always @(posedge clk) rd_seen <= rd_data;

  // Channel 2 counts every cycle while the atomicity test runs.
  initial begin
    forever begin
      @(negedge clk);
      if (inc_ch2) rd_data[95:64] = rd_data[95:64] + 32'd1;
    end
  end

  // Per-cycle monitor.
  always @(negedge clk) begin
    logic [38:0] e;
    if (cs_n) cs_high_cnt++; else cs_high_cnt = 0;
    if (!rst_n) begin
      chk("reset_outs", 64'(outs), 64'd0);
    end else begin
      if (!o_miso_oe) chk("miso_when_off", 64'(o_miso), 64'd0);
      if (o_busy) chk("busy_implies_oe", 64'(o_miso_oe), 64'd1);
      if (!cs_n && host_bit < 8) chk("miso_in_cmd", 64'(o_miso), 64'd0);
      if (host_bit >= 41) chk("miso_overrun", 64'(o_miso), 64'd0);
      if (cs_high_cnt >= 6) chk("idle_busy_oe", 64'({o_busy, o_miso_oe}), 64'd0);
      if (o_rd_strobe) begin
        obs_strobe++;
        snap_exp = (cur_addr < NUM_RD) ? rd_seen[cur_addr*32 +: 32] : 32'h0;
      end
      if (o_frame_err) obs_err++;
      if (o_wr_en) begin
        obs_wr++;
        if (exp_wr_q.size() == 0) begin
          chk("wr_unexpected", 64'd1, 64'd0);
        end else begin
          e = exp_wr_q.pop_front();
          chk("wr_addr", 64'(o_wr_addr), 64'(e[38:32]));
          chk("wr_data", 64'(o_wr_data), 64'(e[31:0]));
        end
      end
    end
  end

  // One host frame. mode 0: nrise SCLK pulses; mode 1: CS rises together
  // with SCLK at pulse index stop_at; mode 2: reset asserted at stop_at.
  task automatic frame(input logic [7:0] cmd, input logic [31:0] wdata, input int nrise,
                       input int mode, input int stop_at, output logic [31:0] rx);
    logic [39:0] bits;
    int          done_rises;
    bit          complete;
    bits       = {cmd, wdata};
    rx         = 32'h0;
    done_rises = (mode == 0) ? nrise : stop_at;
    complete   = (done_rises >= 40);
    cur_addr   = int'(cmd[6:0]);
    // Expected outcome from the frame shape.
    if (mode == 2) begin
      last_addr = 7'h0;
      last_data = 32'h0;
    end else begin
      if (cmd[7] && done_rises >= 8) exp_strobe++;
      if (!complete) exp_err++;
      if (complete && !cmd[7]) begin
        exp_wr++;
        exp_wr_q.push_back({cmd[6:0], wdata});
        last_addr = cmd[6:0];
        last_data = wdata;
      end
    end

    @(negedge clk);
    host_bit = 0;
    cs_n     = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < nrise; i++) begin
      mosi = (i < 40) ? bits[39-i] : 1'($urandom_range(1, 0));
      repeat (8) @(negedge clk);
      if (mode != 0 && i == stop_at) begin
        if (mode == 1) begin
          cs_n = 1'b1;
          sclk = 1'b1;
        end else begin
          #2 rst_n = 1'b0;
          #1 chk("reset_async", 64'(outs), 64'd0);
        end
        break;
      end
      sclk = 1'b1;
      host_bit++;
      if (i >= 8 && i < 40) begin
        rx = {rx[30:0], o_miso};
        chk("oe_in_data", 64'(o_miso_oe), 64'd1);
      end
      repeat (8) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (8) @(negedge clk);
    sclk = 1'b0;
    cs_n = 1'b1;
    if (mode == 2) begin
      repeat (4) @(negedge clk);
      rst_n = 1'b1;
    end
    repeat (24) @(negedge clk);

    chk("strobe_count", 64'(obs_strobe), 64'(exp_strobe));
    chk("abort_count", 64'(obs_err), 64'(exp_err));
    chk("write_count", 64'(obs_wr), 64'(exp_wr));
    chk("write_hold", 64'({o_wr_addr, o_wr_data}), 64'({last_addr, last_data}));
    chk("frame_closed", 64'({o_busy, o_miso_oe}), 64'd0);
    if (mode == 0 && cmd[7]) chk("read_word", 64'(rx), 64'(snap_exp));
  endtask

  initial begin
    logic [31:0] rx;
    int          r;
    logic [7:0]  cmd;

    for (int k = 0; k < NUM_RD; k++) rd_data[k*32 +: 32] = $urandom();
    rd_data[31:0]  = 32'h0000_00FF;
    rd_data[63:32] = 32'hA5C3_0F01;

    // Reset.
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("reset_state", 64'(outs), 64'd0);

    // Read channel 1.
    frame(8'h81, 32'h0, 40, 0, 0, rx);
    chk("read_ch1_literal", 64'(rx), 64'hA5C3_0F01);
    chk("read_ch1_strobes", 64'(obs_strobe), 64'd1);
    chk("read_ch1_no_write", 64'(obs_wr), 64'd0);

    // Write 0x1234 to address 0x0B.
    frame(8'h0B, 32'h0000_1234, 40, 0, 0, rx);
    chk("write_addr_literal", 64'(o_wr_addr), 64'h0B);
    chk("write_data_literal", 64'(o_wr_data), 64'h1234);
    chk("write_no_abort", 64'(obs_err), 64'd0);

    // Out-of-range read.
    frame(8'h8F, 32'h0, 40, 0, 0, rx);
    chk("read_oor_literal", 64'(rx), 64'h0);
    chk("read_oor_strobes", 64'(obs_strobe), 64'd2);

    // Abort after 20 data bits, then read channel 0.
    frame(8'h05, 32'hCAFE_F00D, 40, 1, 28, rx);
    chk("abort_err_literal", 64'(obs_err), 64'd1);
    chk("abort_no_write", 64'(obs_wr), 64'd1);
    frame(8'h80, 32'h0, 40, 0, 0, rx);
    chk("read_ch0_after_abort", 64'(rx), 64'hFF);

    // Overrun: 48 SCLK pulses on a write.
    frame(8'h0C, 32'hDEAD_BEEF, 48, 0, 0, rx);
    chk("overrun_data_literal", 64'(o_wr_data), 64'hDEAD_BEEF);
    chk("overrun_one_write", 64'(obs_wr), 64'd2);

    // Atomicity: channel 2 changes every cycle.
    inc_ch2 = 1'b1;
    frame(8'h82, 32'h0, 40, 0, 0, rx);
    inc_ch2 = 1'b0;

    // Reset during data bit 15 of a write, then read channel 0.
    frame(8'h03, 32'h55AA_55AA, 40, 2, 23, rx);
    chk("reset_mid_outs", 64'(outs), 64'd0);
    frame(8'h80, 32'h0, 40, 0, 0, rx);
    chk("read_ch0_after_reset", 64'(rx), 64'hFF);

    // Randomised frames.
    for (int n = 0; n < 36; n++) begin
      @(negedge clk);
      for (int k = 0; k < NUM_RD; k++) rd_data[k*32 +: 32] = $urandom();
      cmd = {1'($urandom_range(1, 0)), 7'($urandom_range(11, 0))};
      r   = $urandom_range(9, 0);
      if (r <= 6)      frame(cmd, $urandom(), 40, 0, 0, rx);
      else if (r == 7) frame(cmd, $urandom(), $urandom_range(50, 41), 0, 0, rx);
      else             frame(cmd, $urandom(), 40, 1, $urandom_range(39, 0), rx);
    end

    chk("write_queue_drained", 64'(exp_wr_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
